// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: default width, opcodes and
// FSM state encodings. The multiplier is compiled in only when ALU_MUL_EN
// is defined.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_PAS = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mul_shift_add.sv
// Sequential WIDTH x WIDTH shift-add multiplier. load captures the operands
// and clears the accumulator; each step consumes one multiplier bit. fin is
// high once WIDTH steps have been taken, with the full product on product.
module mul_shift_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               fin
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Load operands or advance one shift-add step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Multiplier state registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign product = acc_q;
  assign fin     = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU feeding the accumulator: latches op/a/b on start, computes
// the result, and pulses wac/done for one cycle in DONE.
// Optional multiplier: define ALU_MUL_EN to enable opcode 110.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_out,
  output logic             wac,
  output logic             done,
  output logic             busy,
  output logic             zero,
  output logic             carry,
  output logic             err
);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             ill;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_fin;
  logic               mul_load;
  logic               mul_step;

  // Operands are loaded on the accepting edge so that WIDTH steps finish by
  // the time the FSM has spent WIDTH edges in MUL; the final MUL edge only
  // registers the already-complete product.
  assign mul_load = (state_q == ST_IDLE) && start && (op == OP_MUL);
  assign mul_step = ((state_q == ST_EXEC) && (op_q == OP_MUL)) ||
                    ((state_q == ST_MUL) && !mul_fin);

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a       (a),
    .b       (b),
    .product (mul_prod),
    .fin     (mul_fin)
  );

  assign ill = (op_q == OP_ILL);
`else
  assign ill = (op_q == OP_ILL) || (op_q == OP_MUL);
`endif

  // Single-cycle datapath on the latched operands.
  always_comb begin
    sum   = '0;
    res   = '0;
    res_c = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      OP_SUB: begin
        res   = a_q - b_q;
        res_c = (a_q < b_q);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_PAS: res = b_q;
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  // FSM sequencing and result/flag capture on completion.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          state_d = ST_MUL;
        end else
`endif
        begin
          state_d = ST_DONE;
          if (ill) begin
            err_d = 1'b1;
          end else begin
            alu_out_d = res;
            zero_d    = (res == '0);
            carry_d   = res_c;
            err_d     = 1'b0;
          end
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_fin) begin
          state_d   = ST_DONE;
          alu_out_d = mul_prod[WIDTH-1:0];
          zero_d    = (mul_prod[WIDTH-1:0] == '0);
          carry_d   = |mul_prod[2*WIDTH-1:WIDTH];
          err_d     = 1'b0;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
    end
  end

  // err_q is set on entry to DONE for illegal ops, which suppresses the strobe.
  assign done    = (state_q == ST_DONE);
  assign wac     = (state_q == ST_DONE) && !err_q;
  assign busy    = (state_q != ST_IDLE);
  assign alu_out = alu_out_q;
  assign zero    = zero_q;
  assign carry   = carry_q;
  assign err     = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed test of alu_seq with hand-computed expected values.
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] alu_out;
  logic       wac;
  logic       done;
  logic       busy;
  logic       zero;
  logic       carry;
  logic       err;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .alu_out (alu_out),
    .wac     (wac),
    .done    (done),
    .busy    (busy),
    .zero    (zero),
    .carry   (carry),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then scramble inputs to prove they are latched.
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = ~o;
    a     = ~x;
    b     = ~y;
  endtask

  task automatic chk_zero_all(input string tag);
    chk({tag, ".alu"},   16'(alu_out), 16'h00);
    chk({tag, ".wac"},   16'(wac),     16'h0);
    chk({tag, ".done"},  16'(done),    16'h0);
    chk({tag, ".busy"},  16'(busy),    16'h0);
    chk({tag, ".zero"},  16'(zero),    16'h0);
    chk({tag, ".carry"}, 16'(carry),   16'h0);
    chk({tag, ".err"},   16'(err),     16'h0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = 8'h00;
    b     = 8'h00;
    #2 reset = 1'b0;
    #1 chk_zero_all("rst");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // ADD F0+20 -> 10, carry out
    issue(3'b000, 8'hF0, 8'h20);
    chk("add.busyN",  16'(busy), 16'h1);
    chk("add.doneN",  16'(done), 16'h0);
    chk("add.wacN",   16'(wac),  16'h0);
    tick();
    chk("add.done",   16'(done),    16'h1);
    chk("add.wac",    16'(wac),     16'h1);
    chk("add.alu",    16'(alu_out), 16'h10);
    chk("add.carry",  16'(carry),   16'h1);
    chk("add.zero",   16'(zero),    16'h0);
    chk("add.err",    16'(err),     16'h0);
    tick();
    chk("add.done2",  16'(done),    16'h0);
    chk("add.wac2",   16'(wac),     16'h0);
    chk("add.busy2",  16'(busy),    16'h0);
    chk("add.hold",   16'(alu_out), 16'h10);

    // Illegal opcode keeps previous result
    issue(3'b111, 8'h12, 8'h34);
    tick();
    chk("ill.done",   16'(done),    16'h1);
    chk("ill.wac",    16'(wac),     16'h0);
    chk("ill.err",    16'(err),     16'h1);
    chk("ill.alu",    16'(alu_out), 16'h10);
    chk("ill.carry",  16'(carry),   16'h1);
    tick();
    chk("ill.busy",   16'(busy),    16'h0);
    chk("ill.errh",   16'(err),     16'h1);

    // SUB equal -> zero, clears err
    issue(3'b001, 8'h05, 8'h05);
    tick();
    chk("sub0.alu",   16'(alu_out), 16'h00);
    chk("sub0.zero",  16'(zero),    16'h1);
    chk("sub0.carry", 16'(carry),   16'h0);
    chk("sub0.err",   16'(err),     16'h0);
    chk("sub0.wac",   16'(wac),     16'h1);
    tick();

    // SUB with borrow
    issue(3'b001, 8'h03, 8'h05);
    tick();
    chk("subb.alu",   16'(alu_out), 16'hFE);
    chk("subb.carry", 16'(carry),   16'h1);
    chk("subb.zero",  16'(zero),    16'h0);
    tick();

    issue(3'b011, 8'hA0, 8'h05);
    tick();
    chk("or.alu",     16'(alu_out), 16'hA5);
    chk("or.carry",   16'(carry),   16'h0);
    tick();

    issue(3'b100, 8'hFF, 8'h0F);
    tick();
    chk("xor.alu",    16'(alu_out), 16'hF0);
    tick();

    issue(3'b101, 8'h11, 8'h5A);
    tick();
    chk("pass.alu",   16'(alu_out), 16'h5A);
    tick();

    // Back-to-back with start held: re-accepted 3 edges later
    start = 1'b1;
    op    = 3'b000;
    a     = 8'h01;
    b     = 8'h02;
    tick();
    chk("b2b.busy0",  16'(busy), 16'h1);
    a = 8'h04;
    tick();
    chk("b2b.alu0",   16'(alu_out), 16'h03);
    chk("b2b.wac0",   16'(wac),     16'h1);
    tick();
    chk("b2b.idle",   16'(busy), 16'h0);
    tick();
    chk("b2b.busy1",  16'(busy), 16'h1);
    start = 1'b0;
    tick();
    chk("b2b.alu1",   16'(alu_out), 16'h06);
    chk("b2b.done1",  16'(done),    16'h1);
    tick();

`ifdef ALU_MUL_EN
    // MUL 0C*0D = 9C, done after edge N+9
    issue(3'b110, 8'h0C, 8'h0D);
    repeat (7) tick();
    tick();
    chk("mul.doneN8", 16'(done), 16'h0);
    chk("mul.busyN8", 16'(busy), 16'h1);
    tick();
    chk("mul.done",   16'(done),    16'h1);
    chk("mul.wac",    16'(wac),     16'h1);
    chk("mul.alu",    16'(alu_out), 16'h9C);
    chk("mul.carry",  16'(carry),   16'h0);
    chk("mul.zero",   16'(zero),    16'h0);
    tick();

    // MUL 20*10 = 0200: low byte zero, high half non-zero
    issue(3'b110, 8'h20, 8'h10);
    repeat (8) tick();
    tick();
    chk("mulh.alu",   16'(alu_out), 16'h00);
    chk("mulh.zero",  16'(zero),    16'h1);
    chk("mulh.carry", 16'(carry),   16'h1);
    tick();

    // start pulsed while busy is ignored
    issue(3'b110, 8'h03, 8'h05);
    tick();
    start = 1'b1;
    op    = 3'b000;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("mulb.doneN8", 16'(done), 16'h0);
    tick();
    chk("mulb.done",  16'(done),    16'h1);
    chk("mulb.alu",   16'(alu_out), 16'h0F);
    tick();
    chk("mulb.busy1", 16'(busy), 16'h0);
    tick();
    chk("mulb.busy2", 16'(busy), 16'h0);
    chk("mulb.done2", 16'(done), 16'h0);

    // Reset at N+4 of a MUL aborts it
    issue(3'b110, 8'h0C, 8'h0D);
    repeat (4) tick();
    reset = 1'b0;
    #1 chk_zero_all("rstmul");
    tick();
    reset = 1'b1;
    repeat (8) tick();
    chk("rstmul.wac",  16'(wac),  16'h0);
    chk("rstmul.done", 16'(done), 16'h0);
`else
    // MUL disabled: opcode 110 is illegal, 2-edge latency
    issue(3'b110, 8'h0C, 8'h0D);
    tick();
    chk("nmul.done",  16'(done),    16'h1);
    chk("nmul.wac",   16'(wac),     16'h0);
    chk("nmul.err",   16'(err),     16'h1);
    chk("nmul.alu",   16'(alu_out), 16'h06);
    tick();
    chk("nmul.busy",  16'(busy), 16'h0);

    // start pulsed while busy is ignored
    issue(3'b000, 8'h01, 8'h01);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busyst.alu", 16'(alu_out), 16'h02);
    chk("busyst.done", 16'(done),   16'h1);
    tick();
    chk("busyst.busy1", 16'(busy), 16'h0);
    tick();
    chk("busyst.busy2", 16'(busy), 16'h0);
    chk("busyst.done2", 16'(done), 16'h0);

    // Reset mid-operation aborts it
    issue(3'b000, 8'h10, 8'h10);
    reset = 1'b0;
    #1 chk_zero_all("rstexec");
    tick();
    reset = 1'b1;
    tick();
    chk("rstexec.done", 16'(done), 16'h0);
`endif

    // First op after reset
    issue(3'b010, 8'hF0, 8'h3C);
    tick();
    chk("and.alu",    16'(alu_out), 16'h30);
    chk("and.wac",    16'(wac),     16'h1);
    chk("and.done",   16'(done),    16'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential 8-bit ALU sitting directly upstream of the accumulator. It takes the accumulator output and a second operand from the data bus, then computes the selected operation. It drives the result onto the accumulator's input bus and issues the one-cycle write strobe that loads it. Logic and add/sub operations take a fixed 2-edge latency; multiply is a multi-cycle shift-add.

## Interface
- WIDTH, 8, operand/result width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  operation code, latched with start
- a  in  WIDTH  operand A (accumulator output)
- b  in  WIDTH  operand B (data bus)
- alu_out  out  WIDTH  registered result, drives accumulator input
- wac  out  1  accumulator write strobe, one cycle
- done  out  1  completion pulse, one cycle
- busy  out  1  high whenever state != IDLE
- zero  out  1  alu_out == 0, updated with each result
- carry  out  1  carry/borrow/overflow flag
- err  out  1  illegal opcode flag, updated with each completion

## Operation
- Opcodes:
  - 000 ADD: a+b; carry = bit WIDTH of the sum.
  - 001 SUB: a−b, mod 2^WIDTH; carry = borrow (a<b).
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 PASS: result = b; carry=0.
  - 110 MUL: 2·WIDTH product. alu_out = low WIDTH bits; carry = 1 if the high half is non-zero.
  - 111 illegal.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE→EXEC on start. op, a and b are latched on the same edge; later changes on a/b/op are ignored.
  - EXEC→DONE for all opcodes except MUL. On this edge, alu_out, zero and carry are registered and err=0.
  - EXEC→MUL for MUL. MUL processes one multiplier bit per edge for WIDTH edges, then →DONE with the result registered.
  - DONE→IDLE unconditionally.
- In DONE, done=1 and wac=1. Exception: illegal opcode gives done=1, wac=0, err=1, and alu_out/zero/carry keep their previous values.
- start is ignored in every state except IDLE; there is no queuing.
- Outputs hold between operations. zero/carry/err change only on completion.

## Timing
- Reset (asynchronous, immediate): state=IDLE; alu_out=0, wac=0, done=0, busy=0, zero=0, carry=0, err=0. Multiplier registers are cleared.
- Reset asserted mid-operation aborts it with no wac. The first start after reset is accepted normally.
- Let edge N be the edge on which start is sampled in IDLE:
  - busy rises after edge N.
  - Non-MUL: result valid and done/wac high during the cycle after edge N+1. IDLE after edge N+2.
  - MUL: done/wac high during the cycle after edge N+1+WIDTH (N+9 for WIDTH=8).
- alu_out is stable during the whole wac cycle and afterwards, so the accumulator samples it on the edge ending that cycle.
- Back-to-back: start held continuously is accepted again on the edge leaving DONE→IDLE+1, i.e. the minimum issue interval is 3 edges.

## Configuration
- ALU_MUL_EN defined: multiplier compiled in; opcode 110 behaves as above.
- ALU_MUL_EN undefined: no multiplier hardware and no MUL state. Opcode 110 is treated as illegal: EXEC→DONE with err=1, wac=0, 2-edge latency.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD … OP_MUL, OP_ILL;
  - FSM state encoding;
  - default WIDTH.
- One sub-module, mul_shift_add: a sequential WIDTH×WIDTH shift-add multiplier with load/step inputs and a 2·WIDTH product. It is instantiated only under ALU_MUL_EN.
- The top-level holds the FSM, the combinational single-cycle datapath and the output registers.

## Test plan
- ADD a=0xF0, b=0x20 → alu_out=0x10, carry=1, zero=0; done=wac=1 for exactly one cycle after edge N+1; busy low after N+2.
- SUB a=0x05, b=0x05 → 0x00, zero=1, carry=0. SUB a=0x03, b=0x05 → 0xFE, carry=1.
- MUL a=0x0C, b=0x0D → 0x9C, carry=0, done after edge N+9. MUL a=0x20, b=0x10 → 0x00, zero=1, carry=1.
- op=111 after an ADD giving 0x10 → done=1, wac=0, err=1, alu_out stays 0x10. The next legal op clears err.
- start pulsed during MUL busy → ignored, single done. reset low at N+4 of a MUL → all outputs 0 immediately, no wac. A following AND a=0xF0, b=0x3C → 0x30.
- Build without ALU_MUL_EN, op=110 → err=1, wac=0, done after edge N+1.
